// File: rtl/sgmii_align_pkg.sv
// Shared types for the SGMII RX symbol-alignment controller.
// State encoding matches the debug 'state' output of sgmii_rx_align_ctrl.
package sgmii_align_pkg;

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    SLIP   = 3'd1,
    SETTLE = 3'd2,
    VERIFY = 3'd3,
    LOCKED = 3'd4
  } align_state_t;

  localparam int SLIP_POSITIONS = 10;

endpackage

// File: rtl/sgmii_rx_align_ctrl_err_monitor.sv
// Windowed error counter used while locked: trips when ERR_THRESH errors land within
// one window of ERR_WINDOW valid symbols. The trip is combinational so the FSM can leave LOCKED on the same edge.
module sgmii_align_err_monitor #(
  parameter int ERR_WINDOW = 128,
  parameter int ERR_THRESH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic symbol_valid,
  input  logic err,
  output logic trip
);

  localparam int WW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int EW = $clog2(ERR_THRESH + 1);

  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt;
  logic [EW-1:0] err_next;
  logic          win_last;

  assign err_next = err_cnt + EW'(err);
  assign win_last = (win_cnt == WW'(ERR_WINDOW - 1));
  // The error carried by the window's final symbol still counts toward the trip.
  assign trip     = !clear && symbol_valid && (err_next >= EW'(ERR_THRESH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (clear) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (symbol_valid) begin
      if (trip || win_last) begin
        win_cnt <= '0;
        err_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        err_cnt <= err_next;
      end
    end
  end

endmodule

// File: rtl/sgmii_rx_align_ctrl.sv
// SGMII RX comma-alignment controller: hunts K28.5 via gearbox bitslip, verifies, locks, monitors error rate.
// Optional SGMII_ALIGN_STATS_EN adds saturating slip_count / lock_loss_count outputs.
module sgmii_rx_align_ctrl
  import sgmii_align_pkg::*;
#(
  parameter int COMMA_WINDOW = 64,
  parameter int SLIP_SETTLE  = 8,
  parameter int LOCK_COMMAS  = 4,
  parameter int ERR_WINDOW   = 128,
  parameter int ERR_THRESH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        symbol_valid,
  input  logic        is_comma,
  input  logic        symbol_err,
  input  logic        disparity_err,
  output logic        bitslip,
  output logic        locked,
  output logic [3:0]  slip_pos,
  output logic [2:0]  state
`ifdef SGMII_ALIGN_STATS_EN
  ,
  output logic [15:0] slip_count,
  output logic [15:0] lock_loss_count
`endif
);

  localparam int CW = $clog2(COMMA_WINDOW + 1);
  localparam int SW = $clog2(SLIP_SETTLE + 1);
  localparam int GW = $clog2(LOCK_COMMAS + 1);

  align_state_t  state_q, state_d;
  logic [CW-1:0] comma_timer_q, comma_timer_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [3:0]    slip_pos_d;
  logic          err;
  logic          comma_timeout;
  logic          mon_clear;
  logic          mon_trip;

  assign err           = symbol_err | disparity_err;
  assign comma_timeout = (comma_timer_q == CW'(COMMA_WINDOW - 1));
  assign mon_clear     = !enable || (state_q != LOCKED);
  assign state         = state_q;

  sgmii_align_err_monitor #(
    .ERR_WINDOW (ERR_WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_err_monitor (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (mon_clear),
    .symbol_valid (symbol_valid),
    .err          (err),
    .trip         (mon_trip)
  );

  always_comb begin
    state_d       = state_q;
    comma_timer_d = comma_timer_q;
    settle_cnt_d  = '0;
    good_cnt_d    = good_cnt_q;
    slip_pos_d    = slip_pos;
    if (!enable) begin
      state_d       = HUNT;
      comma_timer_d = '0;
      good_cnt_d    = '0;
    end else begin
      case (state_q)
        HUNT: if (symbol_valid) begin
          if (is_comma) begin
            state_d       = VERIFY;
            good_cnt_d    = GW'(1);
            comma_timer_d = '0;
          end else if (comma_timeout) begin
            state_d       = SLIP;
            comma_timer_d = '0;
          end else begin
            comma_timer_d = comma_timer_q + 1'b1;
          end
        end
        SLIP: state_d = SETTLE;
        SETTLE: begin
          if (settle_cnt_q == SW'(SLIP_SETTLE - 1)) begin
            state_d       = HUNT;
            comma_timer_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        // An errored symbol wins over a comma flag on the same symbol.
        VERIFY: if (symbol_valid) begin
          if (err || (!is_comma && comma_timeout)) begin
            state_d       = SLIP;
            comma_timer_d = '0;
            good_cnt_d    = '0;
          end else if (is_comma) begin
            comma_timer_d = '0;
            if (good_cnt_q == GW'(LOCK_COMMAS - 1)) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else begin
            comma_timer_d = comma_timer_q + 1'b1;
          end
        end
        LOCKED: if (mon_trip) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
    if (state_d == SLIP && state_q != SLIP)
      slip_pos_d = (slip_pos == 4'(SLIP_POSITIONS - 1)) ? 4'd0 : slip_pos + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      comma_timer_q <= '0;
      settle_cnt_q  <= '0;
      good_cnt_q    <= '0;
      slip_pos      <= '0;
      bitslip       <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state_q       <= state_d;
      comma_timer_q <= comma_timer_d;
      settle_cnt_q  <= settle_cnt_d;
      good_cnt_q    <= good_cnt_d;
      slip_pos      <= slip_pos_d;
      bitslip       <= (state_d == SLIP);
      locked        <= (state_d == LOCKED);
    end
  end

`ifdef SGMII_ALIGN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_count      <= '0;
      lock_loss_count <= '0;
    end else begin
      if (state_d == SLIP && state_q != SLIP && slip_count != 16'hFFFF)
        slip_count <= slip_count + 16'd1;
      if (state_q == LOCKED && state_d == HUNT && lock_loss_count != 16'hFFFF)
        lock_loss_count <= lock_loss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sgmii_rx_align_ctrl.sv
// Self-checking bench for sgmii_rx_align_ctrl: directed scenarios plus a $urandom gearbox stream,
// all checked against an event-level alignment model. Define SGMII_ALIGN_STATS_EN to also check the counters.
module tb_sgmii_rx_align_ctrl;

  localparam int COMMA_WINDOW = 64;
  localparam int SLIP_SETTLE  = 8;
  localparam int LOCK_COMMAS  = 4;
  localparam int ERR_WINDOW   = 128;
  localparam int ERR_THRESH   = 8;
  localparam int P_HUNT = 0, P_SLIP = 1, P_SETTLE = 2, P_VERIFY = 3, P_LOCKED = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        symbol_valid = 1'b0;
  logic        is_comma = 1'b0;
  logic        symbol_err = 1'b0;
  logic        disparity_err = 1'b0;
  logic        bitslip;
  logic        locked;
  logic [3:0]  slip_pos;
  logic [2:0]  state;
`ifdef SGMII_ALIGN_STATS_EN
  logic [15:0] slip_count;
  logic [15:0] lock_loss_count;
`endif

  int check_count = 0;
  int fail_count  = 0;
  int pulse_count = 0;

  int m_phase, m_since, m_commas, m_settle_left, m_win_sym, m_win_err;
  int m_slip_pos, m_slips, m_losses;

  always #5 clk = ~clk;

  sgmii_rx_align_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .symbol_valid    (symbol_valid),
    .is_comma        (is_comma),
    .symbol_err      (symbol_err),
    .disparity_err   (disparity_err),
    .bitslip         (bitslip),
    .locked          (locked),
    .slip_pos        (slip_pos),
    .state           (state)
`ifdef SGMII_ALIGN_STATS_EN
    ,
    .slip_count      (slip_count),
    .lock_loss_count (lock_loss_count)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_HUNT; m_since = 0; m_commas = 0; m_settle_left = 0;
    m_win_sym = 0; m_win_err = 0; m_slip_pos = 0; m_slips = 0; m_losses = 0;
  endtask

  task automatic model_start_slip();
    m_phase    = P_SLIP;
    m_since    = 0;
    m_commas   = 0;
    m_slip_pos = (m_slip_pos + 1) % 10;
    m_slips++;
  endtask

  // One symbol-clock step of the alignment rules, applied to the pre-edge model state.
  task automatic model_step(input bit en, input bit v, input bit c, input bit e);
    if (!en) begin
      if (m_phase == P_LOCKED) m_losses++;
      m_phase = P_HUNT; m_since = 0; m_commas = 0; m_win_sym = 0; m_win_err = 0;
      return;
    end
    case (m_phase)
      P_HUNT: if (v) begin
        if (c) begin
          m_phase = P_VERIFY; m_commas = 1; m_since = 0;
        end else begin
          m_since++;
          if (m_since == COMMA_WINDOW) model_start_slip();
        end
      end
      P_SLIP: begin
        m_phase = P_SETTLE; m_settle_left = SLIP_SETTLE;
      end
      P_SETTLE: begin
        m_settle_left--;
        if (m_settle_left == 0) begin m_phase = P_HUNT; m_since = 0; end
      end
      P_VERIFY: if (v) begin
        if (e) model_start_slip();
        else if (c) begin
          m_commas++; m_since = 0;
          if (m_commas == LOCK_COMMAS) begin
            m_phase = P_LOCKED; m_commas = 0; m_win_sym = 0; m_win_err = 0;
          end
        end else begin
          m_since++;
          if (m_since == COMMA_WINDOW) model_start_slip();
        end
      end
      default: if (v) begin
        m_win_sym++;
        m_win_err += e ? 1 : 0;
        if (m_win_err >= ERR_THRESH) begin
          m_phase = P_HUNT; m_since = 0; m_win_sym = 0; m_win_err = 0; m_losses++;
        end else if (m_win_sym == ERR_WINDOW) begin
          m_win_sym = 0; m_win_err = 0;
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input bit en, input bit v, input bit c, input bit se, input bit de);
    enable = en; symbol_valid = v; is_comma = c; symbol_err = se; disparity_err = de;
    model_step(en, v, c, se | de);
    @(posedge clk);
    #1;
    if (bitslip === 1'b1) pulse_count++;
    checkOutput("state", 32'(state), 32'(m_phase));
    checkOutput("locked", 32'(locked), 32'(m_phase == P_LOCKED));
    checkOutput("bitslip", 32'(bitslip), 32'(m_phase == P_SLIP));
    checkOutput("slip_pos", 32'(slip_pos), 32'(m_slip_pos));
`ifdef SGMII_ALIGN_STATS_EN
    checkOutput("slip_count", 32'(slip_count), 32'(m_slips));
    checkOutput("lock_loss_count", 32'(lock_loss_count), 32'(m_losses));
`endif
  endtask

  task automatic doReset();
    enable = 1'b0; symbol_valid = 1'b0; is_comma = 1'b0; symbol_err = 1'b0; disparity_err = 1'b0;
    rst_n = 1'b0;
    model_reset();
    pulse_count = 0;
    #3;
    checkOutput("reset_state", 32'(state), 32'(P_HUNT));
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_bitslip", 32'(bitslip), 32'd0);
    checkOutput("reset_slip_pos", 32'(slip_pos), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Gearbox model: commas only appear when the expected slip offset matches the target.
  task automatic lockUp(input int target, input int budget, input string tag);
    int idx = 0;
    int n = 0;
    bit v, c, se;
    while (m_phase != P_LOCKED && n < budget) begin
      v  = ($urandom_range(0, 3) != 0);
      c  = v && (m_slip_pos == target) && (idx % 5 == 0);
      se = v && (m_slip_pos != target) && ($urandom_range(0, 7) == 0);
      if (v) idx++;
      applyStimulus(1'b1, v, c, se, 1'b0);
      n++;
    end
    checkOutput(tag, 32'(locked), 32'd1);
  endtask

  task automatic windowRun(input int n, input int every, input int max_errs);
    int errs = 0;
    bit e;
    for (int i = 0; i < n; i++) begin
      e = (i % every == 0) && (errs < max_errs);
      if (e) errs++;
      applyStimulus(1'b1, 1'b1, (i % 5 == 0), e && (i % 2 == 0), e && (i % 2 == 1));
    end
  endtask

  initial begin
    int target;
    int n;
    bit v, c, se, de;

    doReset();

    // Aligned stream, comma every 5 symbols: lock right after the 4th comma, no slips.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, (i % 5 == 0), 1'b0, 1'b0);
      if (i == 14) checkOutput("pre_lock", 32'(locked), 32'd0);
      if (i == 15) checkOutput("lock_after_4th", 32'(locked), 32'd1);
    end
    checkOutput("aligned_no_slips", 32'(pulse_count), 32'd0);

    // No commas at all: periodic slips, offset wraps past 9.
    doReset();
    for (int i = 0; i < 11 * (COMMA_WINDOW + 1 + SLIP_SETTLE); i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("nocomma_slips", 32'(pulse_count), 32'd11);
    checkOutput("nocomma_wrap", 32'(slip_pos), 32'd1);

    // Commas only at offset 3.
    doReset();
    lockUp(3, 3000, "lock_at_3");
    checkOutput("slips_to_3", 32'(pulse_count), 32'd3);
    checkOutput("pos_3", 32'(slip_pos), 32'd3);

    // Error monitor: 7 errors keep lock, 8th in same window drops it without a slip.
    windowRun(100, 14, 7);
    checkOutput("seven_errs_locked", 32'(locked), 32'd1);
    n = pulse_count;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("eighth_err_unlock", 32'(locked), 32'd0);
    checkOutput("eighth_err_hunt", 32'(state), 32'(P_HUNT));
    checkOutput("loss_no_slip", 32'(pulse_count), 32'(n));
`ifdef SGMII_ALIGN_STATS_EN
    checkOutput("loss_count_1", 32'(lock_loss_count), 32'd1);
`endif

    // Window rollover forgives errors; the final symbol's error still counts.
    lockUp(3, 400, "relock");
    windowRun(ERR_WINDOW, 18, 7);
    windowRun(ERR_WINDOW, 18, 7);
    checkOutput("two_windows_locked", 32'(locked), 32'd1);
    windowRun(ERR_WINDOW - 1, 18, 7);
    checkOutput("pre_final_locked", 32'(locked), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("final_symbol_trip", 32'(locked), 32'd0);

    // Async reset mid-LOCKED clears outputs without an edge.
    lockUp(3, 400, "relock2");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("async_locked", 32'(locked), 32'd0);
    checkOutput("async_slip_pos", 32'(slip_pos), 32'd0);
    checkOutput("async_state", 32'(state), 32'(P_HUNT));
    checkOutput("async_bitslip", 32'(bitslip), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Comma and error on the same VERIFY symbol: slip, and the comma is not counted.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("comma_err_slip", 32'(state), 32'(P_SLIP));
    checkOutput("comma_err_pulse", 32'(bitslip), 32'd1);
    checkOutput("comma_err_unlocked", 32'(locked), 32'd0);

    // enable=0 while verifying at offset 3: back to HUNT, offset held.
    doReset();
    n = 0;
    while (m_phase != P_VERIFY && n < 3000) begin
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(1'b1, v, v && (m_slip_pos == 3), 1'b0, 1'b0);
      n++;
    end
    checkOutput("reached_verify", 32'(state), 32'(P_VERIFY));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("disable_hunt", 32'(state), 32'(P_HUNT));
    checkOutput("disable_pos_held", 32'(slip_pos), 32'd3);

    // Randomised gearbox stream with occasional disables and target moves.
    doReset();
    target = $urandom_range(0, 9);
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 999) target = $urandom_range(0, 9);
      v  = ($urandom_range(0, 4) != 0);
      c  = v && (m_slip_pos == target) && ($urandom_range(0, 4) == 0);
      se = v && ($urandom_range(0, (m_slip_pos == target) ? 29 : 5) == 0);
      de = v && ($urandom_range(0, 59) == 0);
      applyStimulus(($urandom_range(0, 299) != 0), v, c, se, de);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
